// File: rtl/uart_temp_pwm_capture.sv
// uart_temp_pwm_capture
//   Measures the period and duty cycle of a PWM temperature-sensor output and
//   offers each result to a downstream UART formatter over a valid/ready
//   handshake.
//   The raw input is synchronised first. A counter measures one full period,
//   from one rising edge to the next. An 8-step restoring divider then turns
//   the high time into duty = floor(high*256/period). The result is held
//   until the formatter accepts it.
//   If no rising edge arrives before the period counter saturates, the block
//   reports a timeout instead of a measurement.
//
// Ports
//   clk            : single clock, all state on the rising edge
//   reset          : asynchronous, active-high; clears every flop
//   pwm_in_data_i  : raw PWM input, asynchronous to clk
//   sample_valid_o : result available (registered, independent of ready)
//   sample_ready_i : downstream accepts the result
//   duty_o         : floor(high*256/period), or 0x00/0xFF on timeout
//   period_o       : measured period in clk cycles (all ones on timeout)
//   err_o          : 1 when the result is a timeout
module uart_temp_pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in_data_i,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic [7:0]       duty_o,
  output logic [CNT_W-1:0] period_o,
  output logic             err_o
);

  typedef enum logic [1:0] {WAIT_EDGE, MEAS, DIV, OUT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nx;

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_sync_p2;
  logic             w_rise;
  logic             w_timeout;

  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_divisor;
  logic [CNT_W-1:0] r_rem;
  logic [7:0]       r_quo;
  logic [2:0]       r_div_cnt;
  logic             r_ovf;

  logic [7:0]       r_duty;
  logic [CNT_W-1:0] r_period;
  logic             r_err;

  logic [CNT_W:0]   w_rem_sh;
  logic [CNT_W:0]   w_rem_sub;
  logic             w_ge;
  logic [CNT_W-1:0] w_rem_nx;
  logic [7:0]       w_quo_nx;

  // The quotient cannot exceed 8 bits while high < period. If the high count
  // ever reaches the period, the duty is forced to full scale instead of
  // wrapping.
  function automatic logic [7:0] sat_duty(input logic ovf, input logic [7:0] q);
    sat_duty = ovf ? 8'hFF : q;
  endfunction

  // Synchroniser: p0/p1 form the two-flop synchroniser (p1 is the clean
  // level), p2 is the one-cycle-delayed copy used for edge detection.
  assign w_rise    = r_sync_p1 & ~r_sync_p2;
  assign w_timeout = (r_period_cnt == CNT_MAX);

  // One restoring-division step. The remainder stays below the divisor, so
  // the shifted value fits in CNT_W+1 bits.
  always_comb begin
    w_rem_sh  = {r_rem, 1'b0};
    w_rem_sub = w_rem_sh - {1'b0, r_divisor};
    w_ge      = (w_rem_sh >= {1'b0, r_divisor});
    w_rem_nx  = w_ge ? w_rem_sub[CNT_W-1:0] : w_rem_sh[CNT_W-1:0];
    w_quo_nx  = {r_quo[6:0], w_ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_EDGE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // A rise that coincides with the timeout cycle ends the period normally.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      WAIT_EDGE: if (w_rise) w_state_nx = MEAS;
      MEAS: begin
        if (w_rise)         w_state_nx = DIV;
        else if (w_timeout) w_state_nx = OUT;
      end
      DIV:       if (r_div_cnt == 3'd7) w_state_nx = OUT;
      OUT:       if (sample_ready_i) w_state_nx = WAIT_EDGE;
      default:   w_state_nx = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0    <= 1'b0;
      r_sync_p1    <= 1'b0;
      r_sync_p2    <= 1'b0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_divisor    <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_div_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_duty       <= '0;
      r_period     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_sync_p0 <= pwm_in_data_i;
      r_sync_p1 <= r_sync_p0;
      r_sync_p2 <= r_sync_p1;
      case (r_state)
        WAIT_EDGE: begin
          // The rise cycle itself is the first cycle of the period, and the
          // input is high in that cycle.
          r_period_cnt <= w_rise ? CNT_ONE : '0;
          r_high_cnt   <= w_rise ? CNT_ONE : '0;
        end
        MEAS: begin
          if (w_rise) begin
            // The current counts cover the cycles up to the one before this
            // rise, which is exactly one period.
            r_period  <= r_period_cnt;
            r_divisor <= r_period_cnt;
            r_rem     <= r_high_cnt;
            r_ovf     <= (r_high_cnt >= r_period_cnt);
            r_quo     <= '0;
            r_div_cnt <= '0;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_period <= CNT_MAX;
            r_duty   <= r_sync_p1 ? 8'hFF : 8'h00;
          end else begin
            r_period_cnt <= r_period_cnt + CNT_ONE;
            if (r_sync_p1) r_high_cnt <= r_high_cnt + CNT_ONE;
          end
        end
        DIV: begin
          r_rem     <= w_rem_nx;
          r_quo     <= w_quo_nx;
          r_div_cnt <= r_div_cnt + 3'd1;
          if (r_div_cnt == 3'd7) begin
            r_duty <= sat_duty(r_ovf, w_quo_nx);
            r_err  <= 1'b0;
          end
        end
        default: begin
          r_period_cnt <= '0;
          r_high_cnt   <= '0;
        end
      endcase
    end
  end

  assign sample_valid_o = (r_state == OUT);
  assign duty_o         = r_duty;
  assign period_o       = r_period;
  assign err_o          = r_err;

endmodule

// File: tb/tb_uart_temp_pwm_capture.sv
// Directed testbench for uart_temp_pwm_capture.
// A background generator drives the PWM input on falling clock edges and
// records the cycle number of every rising edge it produces. The main
// sequence runs directed cases with hand-computed expected results.
module tb_uart_temp_pwm_capture;

  localparam int CNT_W = 12;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             pwm_in_data_i;
  logic             sample_valid_o;
  logic             sample_ready_i;
  logic [7:0]       duty_o;
  logic [CNT_W-1:0] period_o;
  logic             err_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // generator controls (written by the main sequence only)
  bit gen_en     = 0;
  bit gen_level  = 0;
  bit gen_glitch = 0;
  int gen_period = 1;
  int gen_high   = 0;
  int gen_start  = 0;
  // generator status (written by the generator only)
  int rise_cyc   = 0;
  int rise_num   = 0;
  int ph;

  uart_temp_pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pwm_in_data_i  (pwm_in_data_i),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .duty_o         (duty_o),
    .period_o       (period_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial pwm_in_data_i = 1'b0;
  always @(negedge clk) begin
    if (gen_en) begin
      ph = (cyc - gen_start) % gen_period;
      pwm_in_data_i = (ph < gen_high);
      if (ph == 0) begin
        rise_cyc = cyc;
        rise_num = rise_num + 1;
      end
      // short pulse in the low phase, entirely between two rising edges
      if (gen_glitch && ph == gen_high + 10) begin
        #1 pwm_in_data_i = 1'b1;
        #2 pwm_in_data_i = 1'b0;
      end
    end else begin
      pwm_in_data_i = gen_level;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sample_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    gen_en         = 0;
    gen_level      = 0;
    gen_glitch     = 0;
    sample_ready_i = 1'b0;
    reset          = 1'b1;
    repeat (3) tick();
    check_eq("rst_valid",  32'(sample_valid_o), 0);
    check_eq("rst_duty",   32'(duty_o), 0);
    check_eq("rst_period", 32'(period_o), 0);
    check_eq("rst_err",    32'(err_o), 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic start_gen(input int p, input int h, input bit glitch);
    gen_period = p;
    gen_high   = h;
    gen_glitch = glitch;
    gen_start  = cyc + 1;
    gen_en     = 1;
  endtask

  task automatic run_case(input string tag, input int p, input int h, input int exp_duty,
                          input bit glitch, input bit chk_lat);
    bit ok;
    int base;
    do_reset();
    sample_ready_i = 1'b1;
    base = rise_num;
    start_gen(p, h, glitch);
    wait_valid(3 * p + 60, ok);
    check_eq({tag, "_seen"}, 32'(ok), 1);
    if (chk_lat) begin
      check_eq({tag, "_latency"}, cyc - rise_cyc, 11);
      check_eq({tag, "_rises"}, rise_num - base, 2);
    end
    check_eq({tag, "_period"}, 32'(period_o), p);
    check_eq({tag, "_duty"},   32'(duty_o), exp_duty);
    check_eq({tag, "_err"},    32'(err_o), 0);
  endtask

  task automatic hold_case();
    bit ok;
    int nv;
    do_reset();
    sample_ready_i = 1'b0;
    start_gen(40, 10, 0);
    wait_valid(200, ok);
    check_eq("hold_seen", 32'(ok), 1);
    for (int i = 0; i < 50; i++) begin
      if (i > 0) tick();
      check_eq("hold_out", 32'({sample_valid_o, err_o, duty_o, period_o}),
               32'({1'b1, 1'b0, 8'd64, 12'd40}));
    end
    sample_ready_i = 1'b1;
    tick();
    check_eq("hold_after_xfer", 32'(sample_valid_o), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sample_valid_o) nv++;
    end
    check_eq("hold_single_xfer", nv, 0);
  endtask

  task automatic div_reset_case();
    bit ok;
    int base;
    int c;
    do_reset();
    sample_ready_i = 1'b1;
    start_gen(100, 25, 0);
    wait_valid(360, ok);
    check_eq("dr_first_seen", 32'(ok), 1);
    base = rise_num;
    for (int i = 0; i < 300 && rise_num < base + 2; i++) tick();
    check_eq("dr_reach_rise", rise_num - base, 2);
    c = rise_cyc;
    for (int i = 0; i < 20 && cyc < c + 6; i++) tick();
    check_eq("dr_pre_period", 32'(period_o), 100);
    reset = 1'b1;
    #1;
    check_eq("dr_async_valid",  32'(sample_valid_o), 0);
    check_eq("dr_async_period", 32'(period_o), 0);
    check_eq("dr_async_duty",   32'(duty_o), 0);
    check_eq("dr_async_err",    32'(err_o), 0);
    for (int i = 0; i < 60 && cyc < c + 40; i++) tick();
    reset = 1'b0;
    base  = rise_num;
    wait_valid(400, ok);
    check_eq("dr_next_seen",    32'(ok), 1);
    check_eq("dr_next_rises",   rise_num - base, 2);
    check_eq("dr_next_latency", cyc - rise_cyc, 11);
    check_eq("dr_next_period",  32'(period_o), 100);
    check_eq("dr_next_duty",    32'(duty_o), 64);
  endtask

  task automatic timeout_case(input string tag, input bit stuck_high, input int exp_duty);
    bit ok;
    int t0;
    do_reset();
    sample_ready_i = 1'b1;
    gen_level = 1;
    t0 = cyc + 1;
    if (!stuck_high) begin
      repeat (5) tick();
      gen_level = 0;
    end
    wait_valid(MAXV + 60, ok);
    check_eq({tag, "_seen"},    32'(ok), 1);
    check_eq({tag, "_latency"}, cyc - t0, MAXV + 3);
    check_eq({tag, "_err"},     32'(err_o), 1);
    check_eq({tag, "_period"},  32'(period_o), MAXV);
    check_eq({tag, "_duty"},    32'(duty_o), exp_duty);
  endtask

  initial begin
    reset          = 1'b1;
    sample_ready_i = 1'b0;
    run_case("p100",   100,  25,  64, 0, 1);
    run_case("p200",   200, 150, 192, 0, 1);
    run_case("p3",       3,   2, 170, 0, 0);
    run_case("glitch", 100,  25,  64, 1, 1);
    hold_case();
    div_reset_case();
    timeout_case("to_high", 1, 255);
    timeout_case("to_low",  0, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
